// File: rtl/lsu_stage_if.sv
// Data-memory request/response bus shared by the LSU and data memory.
interface lsu_stage_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic              dmem_req_we;
  logic [ADDR_W-1:0] dmem_req_addr;
  logic [3:0]        dmem_req_wstrb;
  logic [31:0]       dmem_req_wdata;
  logic              dmem_resp_valid;
  logic [31:0]       dmem_resp_rdata;

  modport master (
    output dmem_req_valid,
    output dmem_req_we,
    output dmem_req_addr,
    output dmem_req_wstrb,
    output dmem_req_wdata,
    input  dmem_req_ready,
    input  dmem_resp_valid,
    input  dmem_resp_rdata
  );

  modport slave (
    input  dmem_req_valid,
    input  dmem_req_we,
    input  dmem_req_addr,
    input  dmem_req_wstrb,
    input  dmem_req_wdata,
    output dmem_req_ready,
    output dmem_resp_valid,
    output dmem_resp_rdata
  );
endinterface

// File: rtl/lsu_stage.sv
// Load/store stage: registers execute results, accesses data memory,
// aligns/extends load data and drives the writeback/forwarding bus.
module lsu_stage #(
  parameter int ADDR_W          = 32,
  parameter int EXC_LD_MISALIGN = 4,
  parameter int EXC_ST_MISALIGN = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iex2lsu_valid,
  input  logic [31:0] iex2lsu_pc,
  input  logic [4:0]  iex2lsu_rd,
  input  logic        iex2lsu_rf_we,
  input  logic        iex2lsu_rf_rd_sel1,
  input  logic        iex2lsu_mem_we,
  input  logic        iex2lsu_mem_re,
  input  logic [2:0]  iex2lsu_mem_byte_sel,
  input  logic [31:0] iex2lsu_dout,
  input  logic [31:0] iex2lsu_rf_rd2,
  input  logic        ac2lsu_stall,
  lsu_stage_if.master dmem,
  output logic        lsu2wb_valid,
  output logic [31:0] lsu2wb_pc,
  output logic        lsu2wb_rf_we,
  output logic [4:0]  lsu2wb_rd,
  output logic [31:0] lsu2wb_dout,
  output logic        lsu_except_valid,
  output logic [3:0]  lsu_except_code,
  output logic        lsu2ac_hazard
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rf_we;
    logic        sel1;
    logic        we;
    logic        re;
    logic [2:0]  bsel;
    logic [31:0] dout;
    logic [31:0] rd2;
  } stage_t;

  stage_t      st_q;
  stage_t      st_in;
  state_e      state_q;
  state_e      state_d;
  logic [31:0] lbuf_q;
  logic        load_en;
  logic        in_op;
  logic        mem_op;
  logic        exc;
  logic [1:0]  off;
  logic [31:0] sh;
  logic [31:0] ld_ext;
  logic [3:0]  wstrb;
  logic [31:0] wdata;

  function automatic logic misal(input logic [2:0] bsel,
                                 input logic [1:0] a);
    misal = ((bsel[1:0] == 2'b01) & a[0]) |
            ((bsel[1:0] == 2'b10) & (a != 2'b00));
  endfunction

  assign st_in = '{
    valid: iex2lsu_valid,
    pc:    iex2lsu_pc,
    rd:    iex2lsu_rd,
    rf_we: iex2lsu_rf_we,
    sel1:  iex2lsu_rf_rd_sel1,
    we:    iex2lsu_mem_we,
    re:    iex2lsu_mem_re,
    bsel:  iex2lsu_mem_byte_sel,
    dout:  iex2lsu_dout,
    rd2:   iex2lsu_rf_rd2
  };

  assign lsu2ac_hazard = (state_q == REQ) | (state_q == WAIT);
  assign load_en = ~(ac2lsu_stall | lsu2ac_hazard);

  assign in_op = st_in.valid & (st_in.re | st_in.we) &
                 ~misal(st_in.bsel, st_in.dout[1:0]);

  assign off    = st_q.dout[1:0];
  assign mem_op = st_q.valid & (st_q.re | st_q.we);
  assign exc    = mem_op & misal(st_q.bsel, off);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= '0;
      state_q <= IDLE;
      lbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_en) st_q <= st_in;
      if (state_q == WAIT && dmem.dmem_resp_valid)
        lbuf_q <= dmem.dmem_resp_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (load_en) state_d = in_op ? REQ : IDLE;
      REQ:        if (dmem.dmem_req_ready) state_d = WAIT;
      WAIT:       if (dmem.dmem_resp_valid) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    wstrb = 4'b0000;
    wdata = st_q.rd2;
    if (st_q.we) begin
      case (st_q.bsel[1:0])
        2'b00: begin
          wstrb = 4'b0001 << off;
          wdata = {4{st_q.rd2[7:0]}};
        end
        2'b01: begin
          wstrb = 4'b0011 << {off[1], 1'b0};
          wdata = {2{st_q.rd2[15:0]}};
        end
        default: wstrb = 4'b1111;
      endcase
    end
  end

  assign sh = lbuf_q >> {off, 3'b000};

  always_comb begin
    ld_ext = lbuf_q;
    case (st_q.bsel)
      3'b000:  ld_ext = {{24{sh[7]}}, sh[7:0]};
      3'b100:  ld_ext = {24'd0, sh[7:0]};
      3'b001:  ld_ext = {{16{sh[15]}}, sh[15:0]};
      3'b101:  ld_ext = {16'd0, sh[15:0]};
      default: ld_ext = lbuf_q;
    endcase
  end

  assign dmem.dmem_req_valid = (state_q == REQ);
  assign dmem.dmem_req_we    = st_q.we;
  assign dmem.dmem_req_addr  = st_q.dout[ADDR_W-1:0];
  assign dmem.dmem_req_wstrb = wstrb;
  assign dmem.dmem_req_wdata = wdata;

  assign lsu2wb_valid     = st_q.valid & ~lsu2ac_hazard;
  assign lsu2wb_pc        = st_q.pc;
  assign lsu2wb_rd        = st_q.rd;
  assign lsu2wb_rf_we     = st_q.rf_we & lsu2wb_valid & ~exc;
  assign lsu2wb_dout      = st_q.sel1 ? ld_ext : st_q.dout;
  assign lsu_except_valid = exc;
  assign lsu_except_code  = !exc    ? 4'd0 :
                            st_q.re ? 4'(EXC_LD_MISALIGN) :
                                      4'(EXC_ST_MISALIGN);

endmodule

// File: tb/tb_lsu_stage.sv
// Randomized bench for lsu_stage with a transaction-level model,
// a small data memory and a few directed literal checks.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iex2lsu_valid;
  logic [31:0] iex2lsu_pc;
  logic [4:0]  iex2lsu_rd;
  logic        iex2lsu_rf_we;
  logic        iex2lsu_rf_rd_sel1;
  logic        iex2lsu_mem_we;
  logic        iex2lsu_mem_re;
  logic [2:0]  iex2lsu_mem_byte_sel;
  logic [31:0] iex2lsu_dout;
  logic [31:0] iex2lsu_rf_rd2;
  logic        ac2lsu_stall;
  logic        lsu2wb_valid;
  logic [31:0] lsu2wb_pc;
  logic        lsu2wb_rf_we;
  logic [4:0]  lsu2wb_rd;
  logic [31:0] lsu2wb_dout;
  logic        lsu_except_valid;
  logic [3:0]  lsu_except_code;
  logic        lsu2ac_hazard;

  lsu_stage_if #(.ADDR_W(32)) dm ();

  always #5 clk = ~clk;

  lsu_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .iex2lsu_valid        (iex2lsu_valid),
    .iex2lsu_pc           (iex2lsu_pc),
    .iex2lsu_rd           (iex2lsu_rd),
    .iex2lsu_rf_we        (iex2lsu_rf_we),
    .iex2lsu_rf_rd_sel1   (iex2lsu_rf_rd_sel1),
    .iex2lsu_mem_we       (iex2lsu_mem_we),
    .iex2lsu_mem_re       (iex2lsu_mem_re),
    .iex2lsu_mem_byte_sel (iex2lsu_mem_byte_sel),
    .iex2lsu_dout         (iex2lsu_dout),
    .iex2lsu_rf_rd2       (iex2lsu_rf_rd2),
    .ac2lsu_stall         (ac2lsu_stall),
    .dmem                 (dm),
    .lsu2wb_valid         (lsu2wb_valid),
    .lsu2wb_pc            (lsu2wb_pc),
    .lsu2wb_rf_we         (lsu2wb_rf_we),
    .lsu2wb_rd            (lsu2wb_rd),
    .lsu2wb_dout          (lsu2wb_dout),
    .lsu_except_valid     (lsu_except_valid),
    .lsu_except_code      (lsu_except_code),
    .lsu2ac_hazard        (lsu2ac_hazard)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rf_we;
    logic        sel1;
    logic        we;
    logic        re;
    logic [2:0]  bs;
    logic [31:0] dout;
    logic [31:0] rd2;
  } ins_t;

  ins_t        cur;
  ins_t        nx;
  ins_t        ap;
  bit          req_pend;
  bit          resp_pend;
  logic [31:0] lbuf;
  logic [31:0] mem [64];
  int          pend_cnt = -1;
  logic [31:0] pend_rdata;
  int          lat = -1;
  bit          n_ready = 1'b1;
  bit          n_stall = 1'b0;
  bit          force_resp = 1'b0;
  bit          rnd = 1'b0;
  logic        s_rv;
  logic        s_we;
  logic [31:0] s_addr;
  logic [3:0]  s_strb;
  logic [31:0] s_wdata;
  int          nvec = 0;
  int          nmis = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic ins_t mk(logic v, logic [31:0] pc, logic [4:0] rd,
                              logic rf_we, logic sel1, logic we,
                              logic re, logic [2:0] bs,
                              logic [31:0] dout, logic [31:0] rd2);
    ins_t i;
    i.valid = v;  i.pc = pc;   i.rd = rd;   i.rf_we = rf_we;
    i.sel1 = sel1; i.we = we;  i.re = re;   i.bs = bs;
    i.dout = dout; i.rd2 = rd2;
    return i;
  endfunction

  function automatic ins_t bubble();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic int acc_size(ins_t i);
    if (i.bs[1:0] == 2'd0) return 1;
    if (i.bs[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit misal(ins_t i);
    return (i.dout % acc_size(i)) != 0;
  endfunction

  function automatic bit starts_access(ins_t i);
    return i.valid && (i.re || i.we) && !misal(i);
  endfunction

  function automatic logic [31:0] ldext(logic [31:0] w, ins_t i);
    int          o = int'(i.dout % 4);
    logic [31:0] s = w >> (8 * o);
    int          b = int'(s[7:0]);
    int          h = int'(s[15:0]);
    case (i.bs)
      3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] estrb(ins_t i);
    int o = int'(i.dout % 4);
    if (!i.we) return 4'd0;
    if (i.bs[1:0] == 2'd0) return 4'(1 << o);
    if (i.bs[1:0] == 2'd1) return 4'(3 << ((o / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ewdata(ins_t i);
    if (i.bs[1:0] == 2'd0) return 32'(i.rd2[7:0]) * 32'h0101_0101;
    if (i.bs[1:0] == 2'd1) return 32'(i.rd2[15:0]) * 32'h0001_0001;
    return i.rd2;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i = bubble();
    int   k = $urandom_range(0, 3);
    i.valid = ($urandom_range(0, 3) != 0);
    i.pc    = $urandom;
    i.rd    = 5'($urandom);
    i.rd2   = $urandom;
    if (k == 1) begin
      i.re = 1; i.sel1 = 1; i.rf_we = 1;
      case ($urandom_range(0, 4))
        0: i.bs = 3'd0;
        1: i.bs = 3'd1;
        2: i.bs = 3'd2;
        3: i.bs = 3'd4;
        default: i.bs = 3'd5;
      endcase
      i.dout = $urandom_range(0, 255);
    end else if (k == 2) begin
      i.we   = 1;
      i.bs   = 3'($urandom_range(0, 2));
      i.dout = $urandom_range(0, 255);
    end else begin
      i.rf_we = 1'($urandom);
      i.dout  = $urandom;
    end
    if ((i.re || i.we) && $urandom_range(0, 1) == 1) i.dout[1:0] = 2'b00;
    return i;
  endfunction

  // Transaction view: an aligned access is busy until its response lands.
  task automatic model_edge();
    bit busy = req_pend || resp_pend;
    if (resp_pend && dm.dmem_resp_valid) begin
      lbuf = dm.dmem_resp_rdata;
      resp_pend = 0;
    end else if (req_pend && dm.dmem_req_ready) begin
      req_pend = 0;
      resp_pend = 1;
    end
    if (!(ac2lsu_stall || busy)) begin
      cur = ap;
      req_pend = starts_access(ap);
    end
  endtask

  task automatic mem_edge();
    int idx = int'(s_addr[7:2]);
    if (s_rv && dm.dmem_req_ready) begin
      if (s_we)
        for (int b = 0; b < 4; b++)
          if (s_strb[b]) mem[idx][8*b +: 8] = s_wdata[8*b +: 8];
      pend_rdata = mem[idx];
      pend_cnt = (lat >= 0) ? lat : $urandom_range(0, 3);
    end
  endtask

  task automatic drive();
    ap = nx;
    iex2lsu_valid        = ap.valid;
    iex2lsu_pc           = ap.pc;
    iex2lsu_rd           = ap.rd;
    iex2lsu_rf_we        = ap.rf_we;
    iex2lsu_rf_rd_sel1   = ap.sel1;
    iex2lsu_mem_we       = ap.we;
    iex2lsu_mem_re       = ap.re;
    iex2lsu_mem_byte_sel = ap.bs;
    iex2lsu_dout         = ap.dout;
    iex2lsu_rf_rd2       = ap.rd2;
    ac2lsu_stall         = n_stall;
    dm.dmem_req_ready    = n_ready;
    dm.dmem_resp_valid   = 1'b0;
    dm.dmem_resp_rdata   = $urandom;
    if (pend_cnt == 0) begin
      dm.dmem_resp_valid = 1'b1;
      dm.dmem_resp_rdata = pend_rdata;
      pend_cnt = -1;
    end else if (pend_cnt > 0) begin
      pend_cnt--;
    end else if (force_resp) begin
      dm.dmem_resp_valid = 1'b1;
      force_resp = 0;
    end else if (rnd && $urandom_range(0, 7) == 0) begin
      dm.dmem_resp_valid = 1'b1;
    end
  endtask

  task automatic compare();
    bit busy = req_pend || resp_pend;
    bit mop  = cur.valid && (cur.re || cur.we);
    bit exc  = mop && misal(cur);
    bit wbv  = cur.valid && !busy;
    chk("hazard", 32'(lsu2ac_hazard), 32'(busy));
    chk("req_valid", 32'(dm.dmem_req_valid), 32'(req_pend));
    chk("wb_valid", 32'(lsu2wb_valid), 32'(wbv));
    chk("except_valid", 32'(lsu_except_valid), 32'(exc));
    chk("wb_rf_we", 32'(lsu2wb_rf_we), 32'(cur.rf_we && wbv && !exc));
    chk("wb_pc", lsu2wb_pc, cur.pc);
    chk("wb_rd", 32'(lsu2wb_rd), 32'(cur.rd));
    if (exc)
      chk("except_code", 32'(lsu_except_code), cur.re ? 32'd4 : 32'd6);
    if (wbv && !exc)
      chk("wb_dout", lsu2wb_dout, cur.sel1 ? ldext(lbuf, cur) : cur.dout);
    if (req_pend) begin
      chk("req_addr", dm.dmem_req_addr, cur.dout);
      chk("req_we", 32'(dm.dmem_req_we), 32'(cur.we));
      chk("req_wstrb", 32'(dm.dmem_req_wstrb), 32'(estrb(cur)));
      if (cur.we) chk("req_wdata", dm.dmem_req_wdata, ewdata(cur));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      model_edge();
      mem_edge();
    end
    #1;
    if (rnd) begin
      nx      = rand_ins();
      n_stall = ($urandom_range(0, 3) == 0);
      n_ready = ($urandom_range(0, 2) != 0);
    end
    drive();
    @(negedge clk);
    s_rv    = dm.dmem_req_valid;
    s_we    = dm.dmem_req_we;
    s_addr  = dm.dmem_req_addr;
    s_strb  = dm.dmem_req_wstrb;
    s_wdata = dm.dmem_req_wdata;
    compare();
  endtask

  task automatic model_reset();
    cur = bubble();
    req_pend = 0;
    resp_pend = 0;
    lbuf = '0;
    pend_cnt = -1;
    s_rv = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    nx = bubble();
    model_reset();
    drive();
    #1 rst = 1'b1;
    #2;
    chk("rst_wb_valid", 32'(lsu2wb_valid), 32'd0);
    chk("rst_req_valid", 32'(dm.dmem_req_valid), 32'd0);
    chk("rst_hazard", 32'(lsu2ac_hazard), 32'd0);
    chk("rst_except", 32'(lsu_except_valid), 32'd0);
    chk("rst_dout", lsu2wb_dout, 32'd0);
    step();
    step();
    rst = 1'b0;

    nx = mk(1, 32'h100, 5, 1, 0, 0, 0, 0, 32'h1234, 0);
    step();
    nx = bubble();
    step();
    chk("alu_rf_we", 32'(lsu2wb_rf_we), 32'd1);
    chk("alu_rd", 32'(lsu2wb_rd), 32'd5);
    chk("alu_dout", lsu2wb_dout, 32'h1234);
    chk("alu_req", 32'(dm.dmem_req_valid), 32'd0);
    chk("alu_hazard", 32'(lsu2ac_hazard), 32'd0);

    for (int u = 0; u < 2; u++) begin
      mem[0] = 32'h80FF_FF7F;
      lat = 0;
      nx = mk(1, 32'h104, 6, 1, 1, 0, 1, u ? 3'd4 : 3'd0, 32'h103, 0);
      step();
      nx = bubble();
      step();
      chk("lb_hazard1", 32'(lsu2ac_hazard), 32'd1);
      chk("lb_addr", dm.dmem_req_addr, 32'h103);
      step();
      chk("lb_hazard2", 32'(lsu2ac_hazard), 32'd1);
      step();
      chk("lb_hazard3", 32'(lsu2ac_hazard), 32'd0);
      chk("lb_dout", lsu2wb_dout, u ? 32'h0000_0080 : 32'hFFFF_FF80);
      step();
    end

    nx = mk(1, 32'h108, 7, 0, 0, 1, 0, 3'd1, 32'h202, 32'hAAAA_BEEF);
    step();
    nx = bubble();
    step();
    chk("sh_wstrb", 32'(dm.dmem_req_wstrb), 32'hC);
    chk("sh_wdata", dm.dmem_req_wdata, 32'hBEEF_BEEF);
    chk("sh_we", 32'(dm.dmem_req_we), 32'd1);
    step();
    step();
    chk("sh_rf_we", 32'(lsu2wb_rf_we), 32'd0);
    step();

    n_ready = 0;
    nx = mk(1, 32'h200, 8, 1, 1, 0, 1, 3'd2, 32'h104, 0);
    step();
    nx = mk(1, 32'h300, 9, 1, 0, 0, 0, 0, 32'h55, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_req", 32'(dm.dmem_req_valid), 32'd1);
      chk("bp_addr", dm.dmem_req_addr, 32'h104);
      chk("bp_hazard", 32'(lsu2ac_hazard), 32'd1);
      chk("bp_pc", lsu2wb_pc, 32'h200);
    end
    n_ready = 1;
    step();
    step();
    step();
    chk("bp_done", 32'(lsu2wb_valid), 32'd1);
    step();
    chk("bp_next_pc", lsu2wb_pc, 32'h300);
    nx = bubble();
    step();

    nx = mk(1, 32'h400, 10, 1, 1, 0, 1, 3'd2, 32'h101, 0);
    step();
    nx = bubble();
    step();
    chk("lw_mis_exc", 32'(lsu_except_valid), 32'd1);
    chk("lw_mis_code", 32'(lsu_except_code), 32'd4);
    chk("lw_mis_req", 32'(dm.dmem_req_valid), 32'd0);
    chk("lw_mis_rf_we", 32'(lsu2wb_rf_we), 32'd0);
    nx = mk(1, 32'h404, 0, 0, 0, 1, 0, 3'd2, 32'h102, 32'h1);
    step();
    nx = bubble();
    step();
    chk("sw_mis_code", 32'(lsu_except_code), 32'd6);

    lat = 3;
    nx = mk(1, 32'h500, 11, 1, 1, 0, 1, 3'd2, 32'h108, 0);
    step();
    nx = bubble();
    step();
    step();
    chk("wait_hazard", 32'(lsu2ac_hazard), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_mid_req", 32'(dm.dmem_req_valid), 32'd0);
    chk("rst_mid_hazard", 32'(lsu2ac_hazard), 32'd0);
    step();
    step();
    rst = 1'b0;
    lat = -1;
    force_resp = 1;
    step();
    step();
    chk("late_resp_hazard", 32'(lsu2ac_hazard), 32'd0);
    chk("late_resp_wb", 32'(lsu2wb_valid), 32'd0);
    chk("late_resp_req", 32'(dm.dmem_req_valid), 32'd0);

    rnd = 1;
    for (int n = 0; n < 4000; n++) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
